cpu_multicycle: RTL
===================

CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, register/ALU data width (legal >= 8); REG_AW, default 3, register address width (2**REG_AW registers); PC_W, default 32, program counter width.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 PC  output  PC_W  address of the instruction being fetched or executed.
REQ-005 IMEM_REQ  output  1  registered instruction-fetch request.
REQ-006 INSTRUCTION  input  32  fetched word, valid when IMEM_READY=1.
REQ-007 IMEM_READY  input  1  fetch completion strobe from instruction memory.
REQ-008 RETIRE  output  1  one-cycle pulse in the writeback cycle of every instruction.

Function
REQ-009 Instruction fields SHALL be opcode [31:24], destination/offset [23:16], source1 [15:8], source2/immediate [7:0]; register indices use the low REG_AW bits of their field.
REQ-010 Opcodes SHALL be 0x00 loadi, 0x01 mov, 0x02 add, 0x03 sub, 0x04 and, 0x05 or, 0x06 j, 0x07 beq.
REQ-011 Any unlisted opcode SHALL execute as a NOP: no register write, PC advances by 4, RETIRE still pulses.
REQ-012 The FSM SHALL have states IDLE, FETCH, EXEC, WB; IDLE->FETCH unconditionally; FETCH->EXEC on IMEM_READY=1; EXEC->WB unconditionally; WB->FETCH unconditionally.
REQ-013 IMEM_REQ SHALL be 1 exactly while in FETCH; INSTRUCTION SHALL be latched into an internal instruction register in the cycle IMEM_READY=1 is sampled.
REQ-014 IMEM_READY while not in FETCH SHALL be ignored; fetch wait is unbounded.
REQ-015 Minimum latency SHALL be 3 cycles per instruction (FETCH with immediate ready, EXEC, WB).
REQ-016 EXEC SHALL read sources and latch ALU result and zero flag; WB SHALL write the destination register and update PC.
REQ-017 loadi SHALL sign-extend the 8-bit immediate to DATA_W; sub SHALL compute source1 + two's complement of source2, modulo 2**DATA_W; beq compares source1 and source2 by subtraction and zero flag.
REQ-018 Branch/jump target SHALL be PC + 4 + (sign-extended offset << 2), modulo 2**PC_W; j always taken, beq taken when zero=1; otherwise PC + 4, modulo 2**PC_W.
REQ-019 Destination equal to a source SHALL read the pre-write value (write happens only in WB).

Reset
REQ-020 While RESET=0: PC=0, all registers=0, state=IDLE, IMEM_REQ=0, RETIRE=0, instruction register=0, all taking effect without a clock edge.
REQ-021 Reset asserted mid-fetch or mid-execute SHALL abandon the instruction with no register write and no retire.
REQ-022 First fetch after reset release SHALL occur at PC=0, with IMEM_REQ rising one cycle after release (IDLE).

Configuration
REQ-023 Macro CPU_BNE_EN defined: opcode 0x08 SHALL be bne, taken when zero=0, same target rule as beq.
REQ-024 Macro CPU_BNE_EN undefined: opcode 0x08 SHALL be a NOP per REQ-011.

Structure
REQ-025 Package cpu_pkg SHALL hold opcode constants, FSM state type, and the ALU-operation encoding.
REQ-026 One sub-module alu_param (parametrised by DATA_W; ops pass, add, and, or; zero output) SHALL be instantiated; register file, PC logic and FSM stay in cpu_multicycle.

Verification
REQ-027 loadi r1,0x05; loadi r2,0x03; sub r3,r1,r2 with IMEM_READY immediate -> r3=0x02, RETIRE every 3 cycles, final PC=0x0C.
REQ-028 loadi r1,0xFF with DATA_W=16 -> r1=0xFFFF; add r2,r1,r1 -> r2=0xFFFE.
REQ-029 beq offset 0xFE with equal sources at PC=0x10 -> next PC=0x0C; unequal -> 0x14; with CPU_BNE_EN, bne at 0x10 with unequal sources, offset 0x02 -> 0x1C.
REQ-030 IMEM_READY held low 5 cycles in FETCH -> IMEM_REQ stays 1, PC stable, no RETIRE; ready on 6th -> EXEC next cycle.
REQ-031 RESET=0 pulsed during EXEC of add r4,... -> r4 unchanged (0), PC=0, IMEM_REQ=0 immediately, refetch at 0 after IDLE.
REQ-032 Opcode 0x3F, and 0x08 without CPU_BNE_EN -> no register change, PC+4, RETIRE pulses.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, FSM state type and ALU operation encoding for cpu_multicycle
package cpu_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_BNE   = 8'h08;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_AND  = 2'd2,
        ALU_OR   = 2'd3
    } alu_op_t;

endpackage

// File: rtl/alu_param.sv
// rtl/alu_param.sv - combinational ALU: pass, add, and, or, with zero flag
// Ports: i_op (alu_op_t encoding), i_a, i_b operands; o_y result; o_zero set when o_y == 0.
module alu_param
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y,
    output logic              o_zero
);

    always_comb begin
        o_y = i_a;
        case (i_op)
            ALU_PASS: o_y = i_a;
            ALU_ADD:  o_y = i_a + i_b;
            ALU_AND:  o_y = i_a & i_b;
            ALU_OR:   o_y = i_a | i_b;
            default:  o_y = i_a;
        endcase
    end

    assign o_zero = (o_y == '0);

endmodule

// File: rtl/cpu_multicycle.sv
// rtl/cpu_multicycle.sv - multicycle CPU core: IDLE/FETCH/EXEC/WB, register file, PC logic
// Ports: CLK clock; RESET async active-low; PC fetch/exec address; IMEM_REQ fetch request;
//        INSTRUCTION fetched word; IMEM_READY fetch strobe; RETIRE pulse in writeback.
// Optional: define CPU_BNE_EN to decode opcode 0x08 as bne (otherwise a NOP).
module cpu_multicycle
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int PC_W   = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    output logic [PC_W-1:0] PC,
    output logic            IMEM_REQ,
    input  logic [31:0]     INSTRUCTION,
    input  logic            IMEM_READY,
    output logic            RETIRE
);

    state_t              r_state, w_next_state;
    logic [PC_W-1:0]     r_pc;
    logic [31:0]         r_ir;
    logic [DATA_W-1:0]   r_regs [2**REG_AW];
    logic [DATA_W-1:0]   r_alu_res;
    logic                r_zero;
    logic                r_imem_req;
    logic                r_retire;

    logic [7:0]          w_op;
    logic [REG_AW-1:0]   w_rd, w_rs1, w_rs2;
    logic [DATA_W-1:0]   w_src1, w_src2, w_imm_ext;
    logic [1:0]          w_alu_op;
    logic [DATA_W-1:0]   w_alu_a, w_alu_b, w_alu_y;
    logic                w_alu_zero;
    logic                w_wr_en;
    logic                w_taken;
    logic [PC_W-1:0]     w_pc_plus4, w_target;
    logic                w_unused_rs1_hi;

    assign w_op      = r_ir[31:24];
    assign w_rd      = r_ir[16 +: REG_AW];
    assign w_rs1     = r_ir[8 +: REG_AW];
    assign w_rs2     = r_ir[0 +: REG_AW];
    assign w_src1    = r_regs[w_rs1];
    assign w_src2    = r_regs[w_rs2];
    assign w_imm_ext = DATA_W'($signed(r_ir[7:0]));
    // Upper bits of the source1 field carry no information for register indexing.
    assign w_unused_rs1_hi = ^r_ir[15:8+REG_AW];

    assign w_pc_plus4 = r_pc + PC_W'(4);
    assign w_target   = w_pc_plus4 + (PC_W'($signed(r_ir[23:16])) << 2);

    // Decode: subtraction (sub, beq, bne) is an add of the negated second source.
    always_comb begin
        w_alu_op = ALU_PASS;
        w_alu_a  = w_src1;
        w_alu_b  = w_src2;
        w_wr_en  = 1'b0;
        w_taken  = 1'b0;
        case (w_op)
            OP_LOADI: begin w_alu_a = w_imm_ext; w_wr_en = 1'b1; end
            OP_MOV:   begin w_wr_en = 1'b1; end
            OP_ADD:   begin w_alu_op = ALU_ADD; w_wr_en = 1'b1; end
            OP_SUB:   begin w_alu_op = ALU_ADD; w_alu_b = -w_src2; w_wr_en = 1'b1; end
            OP_AND:   begin w_alu_op = ALU_AND; w_wr_en = 1'b1; end
            OP_OR:    begin w_alu_op = ALU_OR;  w_wr_en = 1'b1; end
            OP_J:     begin w_taken = 1'b1; end
            OP_BEQ:   begin w_alu_op = ALU_ADD; w_alu_b = -w_src2; w_taken = r_zero; end
`ifdef CPU_BNE_EN
            OP_BNE:   begin w_alu_op = ALU_ADD; w_alu_b = -w_src2; w_taken = ~r_zero; end
`endif
            default:  ;
        endcase
    end

    alu_param #(.DATA_W(DATA_W)) u_alu (
        .i_op   (w_alu_op),
        .i_a    (w_alu_a),
        .i_b    (w_alu_b),
        .o_y    (w_alu_y),
        .o_zero (w_alu_zero)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = S_FETCH;
            S_FETCH: if (IMEM_READY) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_WB;
            S_WB:    w_next_state = S_FETCH;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_alu_res  <= '0;
            r_zero     <= 1'b0;
            r_imem_req <= 1'b0;
            r_retire   <= 1'b0;
            for (int i = 0; i < 2**REG_AW; i++) r_regs[i] <= '0;
        end else begin
            r_state    <= w_next_state;
            // Both strobes are registered from the next state so they align with it.
            r_imem_req <= (w_next_state == S_FETCH);
            r_retire   <= (w_next_state == S_WB);
            if (r_state == S_FETCH && IMEM_READY) r_ir <= INSTRUCTION;
            if (r_state == S_EXEC) begin
                r_alu_res <= w_alu_y;
                r_zero    <= w_alu_zero;
            end
            if (r_state == S_WB) begin
                if (w_wr_en) r_regs[w_rd] <= r_alu_res;
                r_pc <= w_taken ? w_target : w_pc_plus4;
            end
        end
    end

    assign PC       = r_pc;
    assign IMEM_REQ = r_imem_req;
    assign RETIRE   = r_retire;

endmodule
